// File: rtl/ps2_pkg.sv
// Shared PS/2 definitions: FSM encoding, command bytes, 50 MHz cycle defaults.
package ps2_pkg;

  typedef enum logic [2:0] {
    ST_IDLE      = 3'd0,
    ST_INHIBIT   = 3'd1,
    ST_REQUEST   = 3'd2,
    ST_SEND      = 3'd3,
    ST_ACK       = 3'd4,
    ST_WAIT_IDLE = 3'd5
  } ps2_tx_state_t;

  localparam logic [7:0] CMD_SET_LEDS = 8'hED;
  localparam logic [7:0] CMD_RESET    = 8'hFF;
  localparam logic [7:0] ACK_BYTE     = 8'hFA;

  // 100 us clock inhibit and 15 ms transfer timeout at 50 MHz
  localparam int unsigned DEF_INHIBIT_CYCLES = 5000;
  localparam int unsigned DEF_TIMEOUT_CYCLES = 750000;

  // Counter width for a count of n cycles (0 .. n-1), never below 1 bit
  function automatic int unsigned cnt_width(input int unsigned n);
    return (n < 2) ? 1 : $clog2(n);
  endfunction

  // Odd parity bit: makes the total number of ones in data+parity odd
  function automatic logic odd_parity(input logic [7:0] d);
    return ~^d;
  endfunction

endpackage

// File: rtl/ps2_sync_edge.sv
// Two-flop synchronisers for PS2_CLK/PS2_DAT plus a falling-edge detector on the clock.
module ps2_sync_edge (
  input  logic clock,
  input  logic reset,
  input  logic clk_pin,
  input  logic dat_pin,
  output logic clk_sync,
  output logic dat_sync,
  output logic fall_c
);

  logic [1:0] clk_ff;
  logic [1:0] dat_ff;
  logic       clk_prev;

  // Synchronise both pins and keep the previous synced clock; reset to idle-high line
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      clk_ff   <= 2'b11;
      dat_ff   <= 2'b11;
      clk_prev <= 1'b1;
    end else begin
      clk_ff   <= {clk_ff[0], clk_pin};
      dat_ff   <= {dat_ff[0], dat_pin};
      clk_prev <= clk_ff[1];
    end
  end

  assign clk_sync = clk_ff[1];
  assign dat_sync = dat_ff[1];
  assign fall_c   = clk_prev & ~clk_ff[1];

endmodule

// File: rtl/ps2_host_tx.sv
// Host-to-device PS/2 transmitter: inhibit, request-to-send, 10-bit shift-out, ACK check.
module ps2_host_tx
  import ps2_pkg::*;
#(
  parameter int unsigned INHIBIT_CYCLES = DEF_INHIBIT_CYCLES,
  parameter int unsigned TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
  input  logic       clock,
  input  logic       reset,
  input  logic       cmd_valid,
  input  logic [7:0] cmd_data,
  output logic       cmd_ready,
  input  logic       ps2_clk_in,
  input  logic       ps2_dat_in,
  output logic       ps2_clk_oe,
  output logic       ps2_dat_oe,
  output logic       busy,
  output logic       done,
  output logic       error
);

  localparam int unsigned INH_W = cnt_width(INHIBIT_CYCLES);
  localparam int unsigned TO_W  = cnt_width(TIMEOUT_CYCLES);

  ps2_tx_state_t state, state_d;
  logic [INH_W-1:0] inh_cnt, inh_cnt_d;
  logic [TO_W-1:0]  to_cnt, to_cnt_d;
  logic [3:0]       bit_cnt, bit_cnt_d;
  logic [9:0]       shreg, shreg_d;
  logic             cur_bit, cur_bit_d;
  logic             ack_ok, ack_ok_d;
  logic             clk_oe_d, dat_oe_d, ready_d, busy_d, done_d, error_d;
  logic             clk_sync, dat_sync, fall_c;
  logic             to_hit;

  ps2_sync_edge u_sync (
    .clock    (clock),
    .reset    (reset),
    .clk_pin  (ps2_clk_in),
    .dat_pin  (ps2_dat_in),
    .clk_sync (clk_sync),
    .dat_sync (dat_sync),
    .fall_c   (fall_c)
  );

  assign to_hit = (to_cnt == TO_W'(TIMEOUT_CYCLES - 1));

  // State, counters and registered outputs
  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state      <= ST_IDLE;
      inh_cnt    <= '0;
      to_cnt     <= '0;
      bit_cnt    <= '0;
      shreg      <= '0;
      cur_bit    <= 1'b1;
      ack_ok     <= 1'b0;
      ps2_clk_oe <= 1'b0;
      ps2_dat_oe <= 1'b0;
      cmd_ready  <= 1'b1;
      busy       <= 1'b0;
      done       <= 1'b0;
      error      <= 1'b0;
    end else begin
      state      <= state_d;
      inh_cnt    <= inh_cnt_d;
      to_cnt     <= to_cnt_d;
      bit_cnt    <= bit_cnt_d;
      shreg      <= shreg_d;
      cur_bit    <= cur_bit_d;
      ack_ok     <= ack_ok_d;
      ps2_clk_oe <= clk_oe_d;
      ps2_dat_oe <= dat_oe_d;
      cmd_ready  <= ready_d;
      busy       <= busy_d;
      done       <= done_d;
      error      <= error_d;
    end
  end

  // Next state, datapath updates and next output values (outputs follow the next state)
  always_comb begin
    state_d   = state;
    inh_cnt_d = inh_cnt;
    to_cnt_d  = to_cnt;
    bit_cnt_d = bit_cnt;
    shreg_d   = shreg;
    cur_bit_d = cur_bit;
    ack_ok_d  = ack_ok;
    done_d    = 1'b0;
    error_d   = 1'b0;

    case (state)
      ST_IDLE: begin
        if (cmd_valid) begin
          shreg_d   = {1'b1, odd_parity(cmd_data), cmd_data};
          inh_cnt_d = '0;
          bit_cnt_d = '0;
          state_d   = ST_INHIBIT;
        end
      end
      ST_INHIBIT: begin
        if (inh_cnt == INH_W'(INHIBIT_CYCLES - 1)) begin
          cur_bit_d = 1'b0;
          state_d   = ST_REQUEST;
        end else begin
          inh_cnt_d = inh_cnt + INH_W'(1);
        end
      end
      ST_REQUEST: begin
        to_cnt_d = '0;
        state_d  = ST_SEND;
      end
      ST_SEND: begin
        if (to_hit) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
          if (fall_c) begin
            cur_bit_d = shreg[0];
            shreg_d   = {1'b0, shreg[9:1]};
            bit_cnt_d = bit_cnt + 4'd1;
            if (bit_cnt == 4'd9) state_d = ST_ACK;
          end
        end
      end
      ST_ACK: begin
        if (to_hit) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
          if (fall_c) begin
            ack_ok_d  = ~dat_sync;
            bit_cnt_d = bit_cnt + 4'd1;
            state_d   = ST_WAIT_IDLE;
          end
        end
      end
      ST_WAIT_IDLE: begin
        if (to_hit) begin
          error_d = 1'b1;
          state_d = ST_IDLE;
        end else begin
          to_cnt_d = to_cnt + TO_W'(1);
          if (clk_sync && dat_sync) begin
            done_d  = ack_ok;
            error_d = ~ack_ok;
            state_d = ST_IDLE;
          end
        end
      end
      default: state_d = ST_IDLE;
    endcase

    clk_oe_d = (state_d == ST_INHIBIT) || (state_d == ST_REQUEST);
    dat_oe_d = ((state_d == ST_REQUEST) || (state_d == ST_SEND)) && !cur_bit_d;
    ready_d  = (state_d == ST_IDLE);
    busy_d   = (state_d != ST_IDLE);
  end

endmodule
